// File: rtl/uart_peripheral.sv
// Memory-mapped UART: word 0 RX_DATA, 1 RX_STATUS, 2 TX_DATA, 3 TX_STATUS.
// Define UART_PARITY_EN to add an even parity bit to both directions.
module uart_peripheral #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Select,
  input  logic        Write,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  input  logic        rx,
  output logic        tx
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t           tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d, tx_bit_nxt, rx_bit_q, rx_bit_d;
  logic [7:0]       tx_data_q, tx_data_d, rx_data_q, rx_data_d, rx_shift_q, rx_shift_d;
  logic             tx_q, tx_d, tx_busy;
  logic             rx_sync1_q, rx_sync1_d, rx_sync2_q, rx_sync2_d, rx_prev_q, rx_prev_d;
  logic             rx_valid_q, rx_valid_d, overrun_q, overrun_d, parity_err;
  logic             wr_tx, wr_rxstat;
  logic             unused_bits;
`ifdef UART_PARITY_EN
  logic             parity_err_q, parity_err_d, par_bad_q, par_bad_d;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign unused_bits = ^{Addr[31:2], DataIn[31:8]};
  assign wr_tx       = Select & Write & (Addr[1:0] == 2'd2);
  assign wr_rxstat   = Select & Write & (Addr[1:0] == 2'd1);
  assign tx_busy     = (tx_state_q != ST_IDLE);
  assign tx          = tx_q;

  // Transmitter: tx_d is the line level for the bit that starts next cycle.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    tx_d       = tx_q;
    tx_bit_nxt = tx_bit_q + 3'd1;
    if (tx_state_q == ST_IDLE) begin
      tx_d = 1'b1;
      if (wr_tx) begin
        tx_data_d  = DataIn[7:0];
        tx_state_d = ST_START;
        tx_cnt_d   = '0;
        tx_d       = 1'b0;
      end
    end else if (tx_cnt_q != CNT_LAST) begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end else begin
      tx_cnt_d = '0;
      case (tx_state_q)
        ST_START: begin
          tx_state_d = ST_DATA;
          tx_bit_d   = '0;
          tx_d       = tx_data_q[0];
        end
        ST_DATA: begin
          if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_state_d = ST_PARITY;
            tx_d       = ^tx_data_q;
`else
            tx_state_d = ST_STOP;
            tx_d       = 1'b1;
`endif
          end else begin
            tx_bit_d = tx_bit_nxt;
            tx_d     = tx_data_q[tx_bit_nxt];
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          tx_state_d = ST_STOP;
          tx_d       = 1'b1;
        end
`endif
        default: begin
          tx_state_d = ST_IDLE;
          tx_d       = 1'b1;
        end
      endcase
    end
  end

  // Receiver: bits are sampled mid-period, measured from the detected falling edge.
  always_comb begin
    rx_sync1_d = rx;
    rx_sync2_d = rx_sync1_q;
    rx_prev_d  = rx_sync2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
`ifdef UART_PARITY_EN
    parity_err_d = parity_err_q;
    par_bad_d    = par_bad_q;
`endif
    if (wr_rxstat) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
`ifdef UART_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync2_q) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (rx_cnt_q == CNT_MID) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_d = ST_PARITY;
`else
            rx_state_d = ST_STOP;
`endif
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          par_bad_d  = rx_sync2_q ^ (^rx_shift_q);
          rx_state_d = ST_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          if (rx_sync2_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            // A clear on the completing edge leaves only the new byte flagged.
            if (rx_valid_q && !wr_rxstat) overrun_d = 1'b1;
`ifdef UART_PARITY_EN
            if (par_bad_q) parity_err_d = 1'b1;
`endif
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
`ifdef UART_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      rx_sync1_q <= rx_sync1_d;
      rx_sync2_q <= rx_sync2_d;
      rx_prev_q  <= rx_prev_d;
`ifdef UART_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
`ifdef UART_PARITY_EN
    par_bad_q  <= par_bad_d;
`endif
  end

  always_comb begin
    DataOut = '0;
    if (Select) begin
      case (Addr[1:0])
        2'd0:    DataOut[7:0] = rx_data_q;
        2'd1:    DataOut[2:0] = {parity_err, overrun_q, rx_valid_q};
        2'd2:    DataOut[7:0] = tx_data_q;
        default: DataOut[0]   = tx_busy;
      endcase
    end
  end
endmodule

// File: doc/uart_peripheral.md
UART_PERIPHERAL -- requirements
Module: uart_peripheral

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: Select  input  1  chip select from memory map decoder (UART window).
REQ-005 SHALL have port: Write  input  1  write strobe from decoder; qualified by Select.
REQ-006 SHALL have port: Addr  input  32  word index within UART window; only Addr[1:0] decoded.
REQ-007 SHALL have port: DataIn  input  32  store data from processor.
REQ-008 SHALL have port: DataOut  output  32  load data to decoder, combinational from registers.
REQ-009 SHALL have port: rx  input  1  asynchronous serial input, idle high.
REQ-010 SHALL have port: tx  output  1  serial output, idle high.

Function
REQ-011 Register map (word index): 0 RX_DATA (R, bits[7:0]); 1 RX_STATUS (R: bit0 rx_valid, bit1 overrun; W any value clears both); 2 TX_DATA (W bits[7:0] starts frame; R returns last written byte); 3 TX_STATUS (R: bit0 tx_busy; W ignored).
REQ-012 Unused DataOut bits SHALL read 0; DataOut SHALL be 0 when Select=0.
REQ-013 Register writes SHALL occur on the rising edge where Select=1 and Write=1; no effect otherwise.
REQ-014 Frame: 1 start bit (0), 8 data bits LSB first, optional parity (REQ-031), 1 stop bit (1); each bit exactly CLKS_PER_BIT cycles.
REQ-015 TX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on TX_DATA write while tx_busy=0; START->DATA, DATA->(PARITY or STOP) after 8th bit, PARITY->STOP, STOP->IDLE after bit period.
REQ-016 tx SHALL go low on the cycle after the accepting write edge; tx_busy SHALL be 1 from that cycle until STOP completes.
REQ-017 TX_DATA write while tx_busy=1 SHALL be ignored (no restart, no corruption of frame in flight).
REQ-018 rx SHALL pass a 2-flop synchronizer before use; RX latency from line to detection = 2 cycles.
REQ-019 RX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronized falling edge; START samples at CLKS_PER_BIT/2 (integer divide); if line high, return to IDLE (glitch reject).
REQ-020 Data/parity/stop bits SHALL be sampled every CLKS_PER_BIT cycles after the mid-start sample.
REQ-021 On valid stop (1): RX_DATA updated, rx_valid=1; if rx_valid already 1, overrun=1 and RX_DATA still overwritten with new byte.
REQ-022 Stop sampled 0 (framing error): byte discarded, rx_valid/RX_DATA unchanged, FSM returns to IDLE.
REQ-023 Simultaneous RX_STATUS clear write and byte completion on same edge: completion wins (rx_valid=1, overrun=0).
REQ-024 Reading RX_DATA SHALL NOT clear rx_valid.
REQ-025 Bit counters SHALL be sized for CLKS_PER_BIT and wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-026 rst_n=0 sampled on rising edge SHALL force both FSMs to IDLE, all counters 0.
REQ-027 Reset values: tx=1, tx_busy=0, RX_DATA=0, TX_DATA=0, rx_valid=0, overrun=0, synchronizer flops=1.
REQ-028 Reset mid-frame SHALL abort the frame; tx returns high the cycle after reset edge.
REQ-029 Writes during reset SHALL be ignored.

Configuration
REQ-030 Macro UART_PARITY_EN SHALL select parity support.
REQ-031 With UART_PARITY_EN defined: even parity bit sent/received between data and stop; RX parity mismatch sets RX_STATUS bit2 (parity_err, cleared with REQ-011 clear) and byte is still stored.
REQ-032 Without it: PARITY states absent, frame 10 bits, RX_STATUS bit2 reads 0.

Verification (bench CLKS_PER_BIT=16, parity off unless stated)
REQ-033 Reset then write 0x55 to word 2 -> tx low 16 cycles, then 1,0,1,0,1,0,1,0 each 16 cycles, high 16; word 3 reads 1 for 160 cycles then 0.
REQ-034 Loop tx->rx, send 0xA3 -> after frame word 1 reads 0x1, word 0 reads 0xA3; write word 1 -> reads 0x0.
REQ-035 Two frames 0x11 then 0x22 received without clear -> word 0=0x22, word 1=0x3.
REQ-036 rx low pulse of 5 cycles -> no byte, rx_valid stays 0; frame with stop=0 -> rx_valid stays 0.
REQ-037 Write 0x0F to word 2, then 0xF0 while busy -> only 0x0F frame on tx; rst_n=0 at cycle 50 -> tx=1 next cycle, word 3=0.
REQ-038 UART_PARITY_EN defined, send 0x07 -> parity bit 1, 11-bit frame; inject wrong parity -> word 1 bit2=1, word 0=0x07.
